zeroriscy_imem_arbiter: RTL and testbench
=========================================

# zeroriscy_imem_arbiter

Shares the core's single instruction-memory port between two requesters: the IF-stage prefetch buffer (port F) and the debug unit's program-memory read path (port D). It sits between the IF stage and the instruction bus, passes the req/gnt/rvalid protocol through with zero added latency, and keeps a FIFO of grant owners so that each in-order response reaches the requester that issued it. Up to `MAX_OUTSTANDING` transactions may be in flight.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions; legal range 1..4.
- `FETCH_PRIO`, default 1: 1 = port F always wins a fresh contest; 0 = round-robin.
- `clk` input 1: core clock.
- `rst` input 1: reset. Synchronous and active-high.
- `f_req_i` input 1: fetch request from the prefetch buffer.
- `f_addr_i` input 32: fetch address.
- `f_gnt_o` output 1: fetch grant.
- `f_rvalid_o` output 1: fetch response valid.
- `d_req_i` input 1: debug read request.
- `d_addr_i` input 32: debug read address.
- `d_gnt_o` output 1: debug grant.
- `d_rvalid_o` output 1: debug response valid.
- `rdata_o` output 32: response data, broadcast to both ports and qualified by each port's rvalid.
- `instr_req_o` output 1: memory request.
- `instr_addr_o` output 32: memory address.
- `instr_gnt_i` input 1: memory grant.
- `instr_rvalid_i` input 1: memory response valid.
- `instr_rdata_i` input 32: memory response data.
- `busy_o` output 1: high while any transaction is outstanding or a request is held.
- `err_o` output 1: sticky; set when a response arrives with no outstanding owner.

## Operation
- **States**
  - ARB: no request is pending at memory.
  - HOLD: a request was presented without a grant; the selection is locked.
- **ARB state**
  - If neither request is high, `instr_req_o` = 0.
  - If exactly one request is high, that port is selected.
  - If both are high: with `FETCH_PRIO`=1, F is selected. With `FETCH_PRIO`=0, the port not granted last is selected. The last-granted pointer resets to D, so F wins the first round-robin contest.
  - When a port is selected and the owner FIFO is not full: `instr_req_o` = 1 and `instr_addr_o` = the selected port's address.
  - If the grant arrives in the same cycle, stay in ARB. If not, go to HOLD.
- **HOLD state**
  - The locked port's request and address drive memory, regardless of the other port.
  - On `instr_gnt_i`, return to ARB.
  - If the locked port drops its request before the grant, return to ARB without a grant. This is a protocol violation by the requester and is tolerated.
- **Grant routing**
  - `f_gnt_o` = `instr_gnt_i` AND `instr_req_o` AND (selected port is F).
  - `d_gnt_o` is formed the same way for D.
  - The non-selected port never sees a grant.
- **Owner FIFO**
  - Depth `MAX_OUTSTANDING`; each entry is 1 bit (F or D).
  - Push the selected owner on every accepted grant.
  - Pop on `instr_rvalid_i`.
  - The head entry routes `instr_rvalid_i` to `f_rvalid_o` or `d_rvalid_o`.
  - `rdata_o` = `instr_rdata_i` unregistered.
- **Full FIFO**
  - `instr_req_o` is forced to 0 and the FSM stays in ARB, even if a pop occurs in the same cycle.
  - This throttle never applies in HOLD: a held request always stays asserted until granted.
  - To guarantee that, ARB only issues a request when the FIFO is not full.
- **Empty FIFO with `instr_rvalid_i`**
  - Neither rvalid output is asserted.
  - `err_o` is set and remains set until `rst`.
- **Simultaneous push and pop** with the FIFO not full: both take effect and the count is unchanged.
- **Reset**
  - Clears the FIFO, the FSM (to ARB), the round-robin pointer and `err_o`.
  - Responses to pre-reset transactions that arrive after reset set `err_o`. The system must quiesce the bus before asserting `rst`.

## Timing
- Combinational pass-through:
  - request and address to memory;
  - grant back to the requesting port;
  - rvalid and rdata to the owning port.
- Registered: state, FIFO pointers, count, round-robin pointer, `err_o`. All registers update on the rising edge of `clk`.
- Added latency: 0 cycles.
- The minimum request-to-response time is set by memory (1 cycle for SRAM-style rvalid).
- While `rst` is high, every output is 0. The first request can be issued in the cycle after `rst` is released.
- `busy_o` = (count ≠ 0) OR (state = HOLD).

## Structure
- Add `imem_owner_e` {OWNER_F, OWNER_D} and `IMEM_MAX_OUTSTANDING_DEFAULT` to `zeroriscy_defines`.
- Sub-module `zeroriscy_owner_fifo`: parameterised depth, 1-bit data, with push/pop/full/empty/head ports. The arbiter FSM and routing logic stay in the top module.

## Test plan
1. **Fetch only.** F requests addr 0x80; the grant arrives the same cycle; rvalid comes 1 cycle later with 0x00000013.
   - `f_gnt_o` = 1 and `f_rvalid_o` = 1 with `rdata_o` = 0x13.
   - D outputs stay 0.
   - `busy_o` returns to 0.
2. **Contention, round-robin.** `FETCH_PRIO`=0; F and D both request every cycle; memory grants every cycle.
   - Grants alternate F, D, F, D.
   - Responses return in the same owner order.
3. **Held request.** D is selected and memory withholds the grant for 3 cycles while F also requests.
   - `instr_addr_o` stays at `d_addr_i` for all 3 cycles.
   - When the grant comes, it goes to D only.
   - F is granted in the next cycle.
4. **Full FIFO.** `MAX_OUTSTANDING`=2; two grants are accepted with no rvalid.
   - `instr_req_o` = 0 while F is still requesting.
   - After one rvalid, the request is reissued in the following cycle.
5. **Spurious response.** `instr_rvalid_i` pulses while the FIFO is empty.
   - Both rvalid outputs stay 0.
   - `err_o` = 1 and remains 1 until a `rst` pulse, after which `err_o` = 0.
6. **Reset mid-operation.** `rst` is asserted for one cycle while in HOLD with 1 transaction outstanding.
   - All outputs read 0 during reset.
   - After reset: `busy_o` = 0 and the FSM is in ARB. With both ports requesting, F wins the first contest.

Source files
------------

// File: rtl/zeroriscy_defines.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | zeroriscy_defines: shared types for the instruction-port arbiter  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package zeroriscy_defines;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } imem_owner_e;

  localparam int unsigned IMEM_MAX_OUTSTANDING_DEFAULT = 2;

  localparam logic [0:0] IMEM_ST_ARB  = 1'b0;
  localparam logic [0:0] IMEM_ST_HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/zeroriscy_owner_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | zeroriscy_owner_fifo: 1-bit FIFO of grant owners, param depth     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module zeroriscy_owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MEM_N = 1 << PTR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [MEM_N-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign push = push_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/zeroriscy_imem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | zeroriscy_imem_arbiter: shares the instr port between fetch/debug |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module zeroriscy_imem_arbiter
  import zeroriscy_defines::*;
#(
  parameter int unsigned MAX_OUTSTANDING = IMEM_MAX_OUTSTANDING_DEFAULT,
  parameter bit          FETCH_PRIO      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  logic [0:0]  state_q, state_d;
  imem_owner_e lock_q, lock_d, last_q, last_d;
  imem_owner_e arb_sel, sel;
  logic        arb_valid, sel_req, mem_req, accept;
  logic        err_q, err_d;
  logic        fifo_full, fifo_empty, fifo_head, fifo_pop;

  zeroriscy_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IMEM_ST_ARB;
      lock_q  <= OWNER_F;
      last_q  <= OWNER_D;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Fresh contest: the pointer holds the last granted port, so RR favours the other.
  always_comb begin
    arb_valid = f_req_i | d_req_i;
    arb_sel   = OWNER_F;
    if (f_req_i && d_req_i) begin
      if (!FETCH_PRIO && (last_q == OWNER_F)) arb_sel = OWNER_D;
    end else if (d_req_i) begin
      arb_sel = OWNER_D;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IMEM_ST_ARB: begin
        lock_d = arb_sel;
        if (mem_req && !instr_gnt_i) state_d = IMEM_ST_HOLD;
      end
      default: begin
        if (instr_gnt_i || !sel_req) state_d = IMEM_ST_ARB;
      end
    endcase
  end

  // HOLD bypasses the full-FIFO throttle; ARB never issues while full.
  always_comb begin
    sel = (state_q == IMEM_ST_HOLD) ? lock_q : arb_sel;
    if (state_q == IMEM_ST_HOLD) begin
      sel_req = (lock_q == OWNER_D) ? d_req_i : f_req_i;
    end else begin
      sel_req = arb_valid && !fifo_full;
    end
    mem_req  = sel_req && !rst;
    accept   = mem_req && instr_gnt_i;
    fifo_pop = instr_rvalid_i && !fifo_empty;
    last_d   = accept ? sel : last_q;
    err_d    = err_q | (instr_rvalid_i & fifo_empty);

    instr_req_o  = mem_req;
    instr_addr_o = rst ? 32'h0 : ((sel == OWNER_D) ? d_addr_i : f_addr_i);
    f_gnt_o      = accept && (sel == OWNER_F);
    d_gnt_o      = accept && (sel == OWNER_D);
    f_rvalid_o   = !rst && fifo_pop && (fifo_head == OWNER_F);
    d_rvalid_o   = !rst && fifo_pop && (fifo_head == OWNER_D);
    rdata_o      = rst ? 32'h0 : instr_rdata_i;
    busy_o       = !rst && (!fifo_empty || (state_q == IMEM_ST_HOLD));
    err_o        = !rst && err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_imem_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_zeroriscy_imem_arbiter: directed scoreboard bench              |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_zeroriscy_imem_arbiter;
  import zeroriscy_defines::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, f_req, d_req, gnt, rv;
  logic [31:0] f_addr, d_addr, rd;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mreq, busy, err;
  logic [31:0] rdata, maddr;
  logic        fp_f_gnt, fp_f_rvalid, fp_d_gnt, fp_d_rvalid, fp_mreq, fp_busy, fp_err;
  logic [31:0] fp_rdata, fp_maddr;

  zeroriscy_imem_arbiter #(.MAX_OUTSTANDING(2), .FETCH_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .rdata_o(rdata), .instr_req_o(mreq), .instr_addr_o(maddr),
    .instr_gnt_i(gnt), .instr_rvalid_i(rv), .instr_rdata_i(rd),
    .busy_o(busy), .err_o(err)
  );

  zeroriscy_imem_arbiter #(.MAX_OUTSTANDING(2), .FETCH_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(fp_f_gnt), .f_rvalid_o(fp_f_rvalid),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(fp_d_gnt), .d_rvalid_o(fp_d_rvalid),
    .rdata_o(fp_rdata), .instr_req_o(fp_mreq), .instr_addr_o(fp_maddr),
    .instr_gnt_i(gnt), .instr_rvalid_i(rv), .instr_rdata_i(rd),
    .busy_o(fp_busy), .err_o(fp_err)
  );

  typedef struct {
    imem_owner_e owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   nerr = 0;
  int   nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then let comb settle.
  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic [31:0] da,
                      input logic g, input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    gnt = g; rv = v; rd = d;
    #1;
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nchk++;
      nerr++;
      $error("FAIL %s: observed=response expected=no entry in scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_f_rvalid"}, {31'b0, f_rvalid}, {31'b0, (e.owner == OWNER_F)});
      chk({tag, "_d_rvalid"}, {31'b0, d_rvalid}, {31'b0, (e.owner == OWNER_D)});
      chk({tag, "_rdata"}, rdata, e.data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {31'b0, mreq},     32'h0);
    chk({tag, "_addr"},  maddr,             32'h0);
    chk({tag, "_fgnt"},  {31'b0, f_gnt},    32'h0);
    chk({tag, "_dgnt"},  {31'b0, d_gnt},    32'h0);
    chk({tag, "_frv"},   {31'b0, f_rvalid}, 32'h0);
    chk({tag, "_drv"},   {31'b0, d_rvalid}, 32'h0);
    chk({tag, "_rdata"}, rdata,             32'h0);
    chk({tag, "_busy"},  {31'b0, busy},     32'h0);
    chk({tag, "_err"},   {31'b0, err},      32'h0);
  endtask

  initial begin
    imem_owner_e own;
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
    gnt = 1'b0; rv = 1'b0; rd = '0;

    // Reset with every input active: all outputs must stay low.
    step(1, 1, 32'h40, 1, 32'h44, 1, 1, 32'hDEAD_BEEF);
    step(1, 1, 32'h40, 1, 32'h44, 1, 1, 32'hDEAD_BEEF);
    chk_all_zero("rst");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_err",  {31'b0, err},  32'h0);

    // 1: fetch only
    step(0, 1, 32'h80, 0, 0, 1, 0, 0);
    chk("t1_req",  {31'b0, mreq},  32'h1);
    chk("t1_addr", maddr,          32'h80);
    chk("t1_fgnt", {31'b0, f_gnt}, 32'h1);
    chk("t1_dgnt", {31'b0, d_gnt}, 32'h0);
    sb.push_back('{OWNER_F, 32'h0000_0013});
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    chk("t1_busy_out", {31'b0, busy}, 32'h1);
    expect_rsp("t1_rsp");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy_idle", {31'b0, busy}, 32'h0);

    // 2: contention, fresh pointers on both instances
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'(32'h100 + k * 4), 1, 32'(32'h200 + k * 4), 1, (k > 0),
           32'(32'hA000_0000 + k - 1));
      own = (k % 2 == 0) ? OWNER_F : OWNER_D;
      chk("t2_fgnt", {31'b0, f_gnt}, {31'b0, (own == OWNER_F)});
      chk("t2_dgnt", {31'b0, d_gnt}, {31'b0, (own == OWNER_D)});
      chk("t2_addr", maddr, (own == OWNER_F) ? 32'(32'h100 + k * 4) : 32'(32'h200 + k * 4));
      chk("t2_fp_fgnt", {31'b0, fp_f_gnt}, 32'h1);
      chk("t2_fp_dgnt", {31'b0, fp_d_gnt}, 32'h0);
      if (k > 0) expect_rsp("t2_rsp");
      sb.push_back('{own, 32'(32'hA000_0000 + k)});
    end
    step(0, 0, 0, 0, 0, 0, 1, 32'hA000_0003);
    expect_rsp("t2_rsp_last");

    // 3: held request for D while F also asks
    step(0, 0, 0, 1, 32'h300, 0, 0, 0);
    chk("t3_req",  {31'b0, mreq}, 32'h1);
    chk("t3_addr", maddr,         32'h300);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 32'h180, 1, 32'h300, 0, 0, 0);
      chk("t3_hold_addr", maddr,          32'h300);
      chk("t3_hold_fgnt", {31'b0, f_gnt}, 32'h0);
      chk("t3_hold_busy", {31'b0, busy},  32'h1);
    end
    step(0, 1, 32'h180, 1, 32'h300, 1, 0, 0);
    chk("t3_gnt_addr", maddr,          32'h300);
    chk("t3_gnt_d",    {31'b0, d_gnt}, 32'h1);
    chk("t3_gnt_f",    {31'b0, f_gnt}, 32'h0);
    sb.push_back('{OWNER_D, 32'h0000_00B0});
    step(0, 1, 32'h180, 0, 0, 1, 1, 32'h0000_00B0);
    chk("t3_f_next", {31'b0, f_gnt}, 32'h1);
    chk("t3_f_addr", maddr,          32'h180);
    expect_rsp("t3_rsp_d");
    sb.push_back('{OWNER_F, 32'h0000_00B1});
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_00B1);
    expect_rsp("t3_rsp_f");

    // 4: full owner FIFO throttles new requests
    step(0, 1, 32'h400, 0, 0, 1, 0, 0);
    chk("t4_g0", {31'b0, f_gnt}, 32'h1);
    sb.push_back('{OWNER_F, 32'h0000_00C0});
    step(0, 1, 32'h404, 0, 0, 1, 0, 0);
    chk("t4_g1", {31'b0, f_gnt}, 32'h1);
    sb.push_back('{OWNER_F, 32'h0000_00C1});
    step(0, 1, 32'h408, 0, 0, 1, 0, 0);
    chk("t4_full_req",  {31'b0, mreq},  32'h0);
    chk("t4_full_fgnt", {31'b0, f_gnt}, 32'h0);
    chk("t4_full_busy", {31'b0, busy},  32'h1);
    step(0, 1, 32'h408, 0, 0, 1, 1, 32'h0000_00C0);
    chk("t4_pop_req", {31'b0, mreq}, 32'h0);
    expect_rsp("t4_rsp0");
    step(0, 1, 32'h408, 0, 0, 1, 0, 0);
    chk("t4_reissue_req",  {31'b0, mreq},  32'h1);
    chk("t4_reissue_fgnt", {31'b0, f_gnt}, 32'h1);
    chk("t4_reissue_addr", maddr,          32'h408);
    sb.push_back('{OWNER_F, 32'h0000_00C2});
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_00C1);
    expect_rsp("t4_rsp1");
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_00C2);
    expect_rsp("t4_rsp2");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_idle_busy", {31'b0, busy}, 32'h0);
    chk("t4_idle_err",  {31'b0, err},  32'h0);

    // 5: spurious response
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_00EE);
    chk("t5_frv", {31'b0, f_rvalid}, 32'h0);
    chk("t5_drv", {31'b0, d_rvalid}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_set", {31'b0, err}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_sticky", {31'b0, err}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_in_rst", {31'b0, err}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_clr", {31'b0, err}, 32'h0);

    // 6: reset while in HOLD with one outstanding
    step(0, 1, 32'h500, 0, 0, 1, 0, 0);
    chk("t6_g0", {31'b0, f_gnt}, 32'h1);
    step(0, 0, 0, 1, 32'h600, 0, 0, 0);
    chk("t6_hold_req", {31'b0, mreq}, 32'h1);
    step(0, 0, 0, 1, 32'h600, 0, 0, 0);
    chk("t6_hold_busy", {31'b0, busy}, 32'h1);
    step(1, 1, 32'h500, 1, 32'h600, 1, 1, 32'h1234_5678);
    chk_all_zero("t6_rst");
    step(0, 1, 32'h500, 1, 32'h600, 1, 0, 0);
    chk("t6_busy", {31'b0, busy},  32'h0);
    chk("t6_fgnt", {31'b0, f_gnt}, 32'h1);
    chk("t6_dgnt", {31'b0, d_gnt}, 32'h0);
    chk("t6_addr", maddr,          32'h500);
    sb.push_back('{OWNER_F, 32'h0000_00D0});
    step(0, 1, 32'h504, 1, 32'h604, 1, 1, 32'h0000_00D0);
    chk("t6_rr_dgnt", {31'b0, d_gnt}, 32'h1);
    chk("t6_rr_addr", maddr,          32'h604);
    expect_rsp("t6_rsp0");
    sb.push_back('{OWNER_D, 32'h0000_00D1});
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_00D1);
    expect_rsp("t6_rsp1");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_end_busy", {31'b0, busy}, 32'h0);
    chk("t6_end_err",  {31'b0, err},  32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
